// File: rtl/salvo_fire_scheduler.sv
// Salvo fire scheduler: round-robin pylon selection with ack wait and gap timing.
// Optional ack timeout with sticky pylon fault masking: define SALVO_ACK_TIMEOUT_EN.
module salvo_fire_scheduler #(
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       target_locked,
    input  logic       salvo_req,
    input  logic [2:0] salvo_size,
    input  logic [3:0] pylon_ready,
    input  logic [3:0] launch_ack,
    output logic [3:0] fire_cmd,
    output logic       salvo_busy,
    output logic       salvo_done,
    output logic       salvo_err,
    output logic [2:0] launched_count,
    output logic [3:0] fault_mask,
    output logic [1:0] sched_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_GAP   = 2'b11
    } state_t;

`ifdef SALVO_ACK_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] size_q, size_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] fault_q, fault_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] tmo_q, tmo_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [3:0] elig;
    logic [1:0] pick;
    logic       found;
    logic       acked;
    logic [2:0] cnt_inc;
    logic       size_ok;

    // Scan downward so the pylon closest to the pointer wins.
    always_comb begin : select
        elig  = pylon_ready & ~fault_q;
        pick  = ptr_q;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[ptr_q + 2'(i)]) begin
                pick  = ptr_q + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            fault_q <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        size_ok = (salvo_size != 3'd0) && (salvo_size <= 3'd4);
        acked   = launch_ack[sel_q];
        cnt_inc = cnt_q + 3'(acked);
        unique case (state_q)
            S_IDLE: begin
                if (salvo_req && target_locked && size_ok) begin
                    size_d  = salvo_size;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!target_locked || !found) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    sel_d   = pick;
                    ptr_d   = pick + 2'd1;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack coinciding with loss of lock still counts.
                if (!target_locked) begin
                    cnt_d   = cnt_inc;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = (cnt_inc != size_q);
                end else if (acked) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == size_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    fault_d[sel_q] = 1'b1;
                    state_d        = S_ISSUE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            S_GAP: begin
                if (!target_locked) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin : outputs
        fire_cmd = '0;
        if ((state_q == S_ISSUE) && target_locked && found) begin
            fire_cmd[pick] = 1'b1;
        end
        salvo_busy = (state_q != S_IDLE);
    end

    assign salvo_done     = done_q;
    assign salvo_err      = err_q;
    assign launched_count = cnt_q;
    assign fault_mask     = fault_q;
    assign sched_state    = state_q;

endmodule

// File: tb/tb_salvo_fire_scheduler.sv
// Bench for salvo_fire_scheduler: vector table, corner sequences and
// randomized salvos against a salvo-level timing model.
module tb_salvo_fire_scheduler;

    localparam int GAP    = 4;
    localparam int TMO    = 8;
    localparam int NOLOCK = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       target_locked;
    logic       salvo_req;
    logic [2:0] salvo_size;
    logic [3:0] pylon_ready;
    logic [3:0] launch_ack;
    logic [3:0] fire_cmd;
    logic       salvo_busy;
    logic       salvo_done;
    logic       salvo_err;
    logic [2:0] launched_count;
    logic [3:0] fault_mask;
    logic [1:0] sched_state;

    salvo_fire_scheduler #(
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .target_locked (target_locked),
        .salvo_req     (salvo_req),
        .salvo_size    (salvo_size),
        .pylon_ready   (pylon_ready),
        .launch_ack    (launch_ack),
        .fire_cmd      (fire_cmd),
        .salvo_busy    (salvo_busy),
        .salvo_done    (salvo_done),
        .salvo_err     (salvo_err),
        .launched_count(launched_count),
        .fault_mask    (fault_mask),
        .sched_state   (sched_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         size;
        logic [3:0] ready;
        int         d;
        int         lk;
        logic [15:0] fires;
        int         nf;
        logic       err;
        int         cnt;
    } vec_t;

    vec_t tbl[8];

    int n_chk  = 0;
    int n_pass = 0;

    int   m_ptr;
    int   m_last_cnt;
    int   m_fc[4];
    int   m_fp[4];
    int   m_nf;
    int   m_done;
    int   m_cnt;
    logic m_err;

    logic [3:0] o_f[8];
    int         o_t[8];
    int         o_nf;
    int         o_cnt;
    logic       o_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Salvo timeline: issue at c, ack at c+d, gap of GAP cycles, next issue.
    // Lock is high on cycles < lk (cycle 0 is the request cycle).
    task automatic model(input int size, input logic [3:0] ready,
                         input int d, input int lk);
        int c, a, p;
        bit hit, fin;
        c = 1; m_nf = 0; m_cnt = 0; m_err = 1'b0; m_done = 0; fin = 0;
        while (!fin) begin
            if (lk <= c) begin
                m_done = c + 1; m_err = 1'b1; fin = 1;
            end else begin
                hit = 0; p = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!hit && ready[(m_ptr + i) % 4]) begin
                        hit = 1; p = (m_ptr + i) % 4;
                    end
                end
                if (!hit) begin
                    m_done = c + 1; m_err = 1'b1; fin = 1;
                end else begin
                    m_fc[m_nf] = c; m_fp[m_nf] = p; m_nf++;
                    m_ptr = (p + 1) % 4;
                    a = c + d;
                    if (lk <= a) begin
                        if (lk == a) m_cnt++;
                        m_done = lk + 1; m_err = (m_cnt != size); fin = 1;
                    end else begin
                        m_cnt++;
                        if (m_cnt == size) begin
                            m_done = a + 1; m_err = 1'b0; fin = 1;
                        end else if (lk <= a + GAP) begin
                            m_done = lk + 1; m_err = 1'b1; fin = 1;
                        end else begin
                            c = a + GAP + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_salvo(input int size, input logic [3:0] ready,
                             input int d, input int lk, input bit noise,
                             input int nidle);
        logic [3:0] ef, ack;
        logic [2:0] sz;
        int prev;
        prev = m_last_cnt;
        model(size, ready, d, lk);
        o_nf = 0; o_err = 1'b0; o_cnt = 0;
        for (int k = 0; k <= m_done; k++) begin
            ef = '0; ack = '0;
            for (int j = 0; j < m_nf; j++) begin
                if (k == m_fc[j]) ef[m_fp[j]] = 1'b1;
                if (k == m_fc[j] + d) ack[m_fp[j]] = 1'b1;
            end
            if (noise) ack = ack | (4'($urandom) & ~ready);
            salvo_req     = (k == 0) || (noise && k < m_done && ($urandom % 3 == 0));
            salvo_size    = (k == 0) ? 3'(size) : 3'($urandom);
            target_locked = (k < lk);
            pylon_ready   = ready;
            launch_ack    = ack;
            @(negedge clk);
            chk($sformatf("cycle%0d fire/done/err/busy", k),
                32'({fire_cmd, salvo_done, salvo_err, salvo_busy}),
                32'({ef, k == m_done, (k == m_done) && m_err,
                     (k > 0) && (k < m_done)}));
            if (k == 0) begin
                chk("hold_count", 32'(launched_count), 32'(prev));
                chk("req_state", 32'(sched_state), 32'(0));
            end
            if (fire_cmd != 4'd0 && o_nf < 8) begin
                o_f[o_nf] = fire_cmd; o_t[o_nf] = k; o_nf++;
            end
            if (k == m_done) begin
                chk("done_count", 32'(launched_count), 32'(m_cnt));
                chk("done_state", 32'(sched_state), 32'(0));
                chk("fault_mask", 32'(fault_mask), 32'(0));
                o_err = salvo_err; o_cnt = 32'(launched_count);
            end
            step();
        end
        m_last_cnt = m_cnt;
        for (int i = 0; i < nidle; i++) begin
            salvo_req = 1'b0;
            target_locked = 1'($urandom);
            salvo_size = 3'($urandom_range(1, 4));
            launch_ack = noise ? 4'($urandom) : 4'd0;
            if (noise && ($urandom % 2 == 0)) begin
                salvo_req = 1'b1;
                if ($urandom % 2 == 0) begin
                    target_locked = 1'b0;
                end else begin
                    target_locked = 1'b1;
                    sz = 3'($urandom % 4);
                    salvo_size = (sz == 3'd0) ? 3'd0 : sz + 3'd4;
                end
            end
            @(negedge clk);
            chk("idle outputs",
                32'({fire_cmd, salvo_done, salvo_err, salvo_busy, sched_state}),
                32'(0));
            chk("idle_count", 32'(launched_count), 32'(m_last_cnt));
            step();
        end
        salvo_req = 1'b0;
        launch_ack = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        tbl[0] = '{3, 4'b1111, 1, NOLOCK, 16'h0421, 3, 1'b0, 3};
        tbl[1] = '{2, 4'b1111, 1, NOLOCK, 16'h0018, 2, 1'b0, 2};
        tbl[2] = '{4, 4'b0101, 1, NOLOCK, 16'h1414, 4, 1'b0, 4};
        tbl[3] = '{2, 4'b0000, 1, NOLOCK, 16'h0000, 0, 1'b1, 0};
        tbl[4] = '{4, 4'b1111, 1, 3,      16'h0002, 1, 1'b1, 1};
        tbl[5] = '{1, 4'b1000, 3, NOLOCK, 16'h0008, 1, 1'b0, 1};
        tbl[6] = '{2, 4'b1111, 2, 3,      16'h0001, 1, 1'b1, 1};
        tbl[7] = '{3, 4'b1111, 1, 7,      16'h0002, 1, 1'b1, 1};

        rst = 1'b1; target_locked = 1'b0; salvo_req = 1'b0;
        salvo_size = '0; pylon_ready = '0; launch_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset outputs",
            32'({fire_cmd, salvo_busy, salvo_done, salvo_err,
                 launched_count, fault_mask, sched_state}), 32'(0));
        step();
        rst = 1'b0;
        m_ptr = 0; m_last_cnt = 0;

        for (int t = 0; t < 8; t++) begin
            run_salvo(tbl[t].size, tbl[t].ready, tbl[t].d, tbl[t].lk, 1'b0, 1);
            chk($sformatf("t%0d nfires", t), 32'(o_nf), 32'(tbl[t].nf));
            for (int j = 0; j < tbl[t].nf; j++)
                chk($sformatf("t%0d fire%0d", t, j), 32'(o_f[j]),
                    32'(tbl[t].fires[4*j +: 4]));
            chk($sformatf("t%0d err", t), 32'(o_err), 32'(tbl[t].err));
            chk($sformatf("t%0d count", t), 32'(o_cnt), 32'(tbl[t].cnt));
            if (t == 0) begin
                chk("spacing01", 32'(o_t[1] - o_t[0]), 32'(GAP + 2));
                chk("spacing12", 32'(o_t[2] - o_t[1]), 32'(GAP + 2));
            end
        end

        // Reset in WAIT_ACK of the second launch, then ignored requests.
        p0 = m_ptr;
        salvo_req = 1'b1; salvo_size = 3'd2; target_locked = 1'b1;
        pylon_ready = 4'hF; launch_ack = '0;
        @(negedge clk); step(); salvo_req = 1'b0;
        @(negedge clk);
        chk("rstseq fire0", 32'(fire_cmd), 32'(1 << p0));
        step();
        launch_ack = 4'(1 << p0);
        @(negedge clk); step(); launch_ack = '0;
        repeat (GAP) begin @(negedge clk); step(); end
        @(negedge clk);
        chk("rstseq fire1", 32'(fire_cmd), 32'(1 << ((p0 + 1) % 4)));
        step();
        @(negedge clk);
        chk("rstseq wait state", 32'(sched_state), 32'(2));
        chk("rstseq count", 32'(launched_count), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        salvo_req = 1'b1; salvo_size = 3'd2; target_locked = 1'b0;
        @(negedge clk);
        chk("rstseq reset outputs",
            32'({fire_cmd, salvo_busy, salvo_done, salvo_err,
                 launched_count, fault_mask, sched_state}), 32'(0));
        m_ptr = 0; m_last_cnt = 0;
        step();
        target_locked = 1'b1; salvo_size = 3'd0;
        @(negedge clk);
        chk("ignore unlocked", 32'({salvo_busy, sched_state}), 32'(0));
        step();
        salvo_size = 3'd5;
        @(negedge clk);
        chk("ignore size0", 32'({salvo_busy, sched_state}), 32'(0));
        step();
        salvo_req = 1'b0;
        @(negedge clk);
        chk("ignore size5", 32'({salvo_busy, sched_state}), 32'(0));
        step();

        for (int r = 0; r < 40; r++) begin
            run_salvo($urandom_range(1, 4), 4'($urandom), $urandom_range(1, 3),
                      ($urandom % 4 == 0) ? $urandom_range(1, 30) : NOLOCK,
                      1'b1, $urandom_range(1, 3));
        end

`ifdef SALVO_ACK_TIMEOUT_EN
        rst = 1'b1; step(); rst = 1'b0;
        salvo_req = 1'b1; salvo_size = 3'd1; target_locked = 1'b1;
        pylon_ready = 4'hF; launch_ack = '0;
        @(negedge clk); step(); salvo_req = 1'b0;
        @(negedge clk);
        chk("tmo fire0", 32'(fire_cmd), 32'(1));
        step();
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            if (k == 9) begin
                chk("tmo pre fault", 32'(fault_mask), 32'(0));
                chk("tmo pre state", 32'(sched_state), 32'(2));
            end
            step();
        end
        @(negedge clk);
        chk("tmo fault", 32'(fault_mask), 32'(1));
        chk("tmo fire1", 32'(fire_cmd), 32'(2));
        step();
        launch_ack = 4'b0010;
        @(negedge clk); step(); launch_ack = '0;
        @(negedge clk);
        chk("tmo done/err", 32'({salvo_done, salvo_err}), 32'(2));
        chk("tmo count", 32'(launched_count), 32'(1));
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/salvo_fire_scheduler.md
SALVO_FIRE_SCHEDULER -- requirements
Module: salvo_fire_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 4, meaning idle cycles between consecutive launches in a salvo, legal range 1..15.
REQ-002 Parameter ACK_TIMEOUT, default 8, meaning cycles to wait for launch acknowledge before declaring the pylon faulty, legal range 2..15.
REQ-003 clk  input  1  single clock, all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 target_locked  input  1  level, target lock from fire control.
REQ-006 salvo_req  input  1  one-cycle request to start a salvo.
REQ-007 salvo_size  input  3  missiles requested, sampled with salvo_req, legal 1..4.
REQ-008 pylon_ready  input  4  per-pylon level: pylon armed and has ammunition.
REQ-009 launch_ack  input  4  per-pylon one-cycle launch acknowledge.
REQ-010 fire_cmd  output  4  one-hot one-cycle fire pulse to the selected pylon.
REQ-011 salvo_busy  output  1  high from salvo acceptance until completion.
REQ-012 salvo_done  output  1  one-cycle pulse at salvo completion.
REQ-013 salvo_err  output  1  valid with salvo_done; 1 = fewer launched than requested.
REQ-014 launched_count  output  3  launches acknowledged in the current or last salvo.
REQ-015 fault_mask  output  4  sticky per-pylon fault flags.
REQ-016 sched_state  output  2  IDLE=00, ISSUE=01, WAIT_ACK=10, GAP=11.

Function
REQ-017 The scheduler SHALL accept salvo_req only in IDLE with target_locked=1 and salvo_size in 1..4; otherwise the request SHALL be ignored without response.
REQ-018 On acceptance it SHALL latch salvo_size, clear launched_count, set salvo_busy, and enter ISSUE next cycle.
REQ-019 In ISSUE it SHALL select the eligible pylon (pylon_ready & ~fault_mask) first at or after the round-robin pointer (modulo 4), pulse its fire_cmd bit for exactly one cycle, and enter WAIT_ACK.
REQ-020 The round-robin pointer SHALL advance to (selected+1) mod 4 after each issue and SHALL persist across salvos; reset value 0.
REQ-021 If no pylon is eligible in ISSUE, it SHALL end the salvo: salvo_done=1, salvo_err=1, return to IDLE, no fire_cmd.
REQ-022 In WAIT_ACK, launch_ack on the selected pylon SHALL increment launched_count; acks on non-selected pylons SHALL be ignored.
REQ-023 After an ack, if launched_count equals the latched size the salvo SHALL end (salvo_done=1, salvo_err=0, IDLE) in the cycle after the ack, else it SHALL enter GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles then enter ISSUE; fire_cmd pulses within a salvo are therefore separated by at least GAP_CYCLES+2 cycles.
REQ-025 Loss of target_locked in ISSUE, WAIT_ACK or GAP SHALL abort: no further fire_cmd, salvo_done=1, salvo_err=1, IDLE next cycle; an ack arriving in the abort cycle SHALL still be counted.
REQ-026 fire_cmd SHALL never have more than one bit set and SHALL be 0 outside ISSUE.
REQ-027 salvo_busy SHALL drop in the same cycle salvo_done pulses; salvo_done and salvo_err SHALL be 0 in all other cycles.
REQ-028 launched_count SHALL hold its value in IDLE until the next accepted salvo.

Reset
REQ-029 rst SHALL take priority over all inputs, including mid-salvo: state IDLE, fire_cmd=0, salvo_busy=0, salvo_done=0, salvo_err=0, launched_count=0, fault_mask=0, pointer=0.

Configuration
REQ-030 With SALVO_ACK_TIMEOUT_EN defined, if no matching ack arrives within ACK_TIMEOUT cycles of the fire_cmd pulse, the scheduler SHALL set that pylon's fault_mask bit and return to ISSUE (retry on next eligible pylon, no GAP); fault_mask bits clear only on rst.
REQ-031 Without SALVO_ACK_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely (exit only by ack, unlock abort or rst) and fault_mask SHALL remain 0.

Verification
REQ-032 Lock=1, all pylons ready, salvo_req size=3 -> fire_cmd 0001, 0010, 0100 each acked after 1 cycle, spacing GAP_CYCLES+2, salvo_done=1 salvo_err=0, launched_count=3.
REQ-033 Second salvo size=2 after the above -> fire_cmd 1000 then 0001 (pointer wrap), launched_count=2.
REQ-034 pylon_ready=0101, size=4 -> fires pylons 0,2,0,2 in round-robin order; pylon_ready=0000 -> immediate salvo_done with salvo_err=1, no fire_cmd.
REQ-035 Drop target_locked during GAP after 1 launch of size=4 -> no further fire_cmd, salvo_done=1 salvo_err=1, launched_count=1.
REQ-036 SALVO_ACK_TIMEOUT_EN, pylon 0 never acks, size=1 -> after 8 cycles fault_mask=0001, fire_cmd 0010 next, ack -> salvo_done salvo_err=0.
REQ-037 Assert rst in WAIT_ACK -> next cycle all outputs at reset values; salvo_req with lock=0 or salvo_size=0 -> ignored, sched_state stays 00.
